// File: rtl/edge_pkg.sv
// Shared types and default geometry for the Sobel edge frame sequencer.
package edge_pkg;

  typedef enum logic [1:0] {IDLE, FEED, FLUSH, DONE} state_t;

  localparam int IMG_W_DEF = 480;
  localparam int IMG_H_DEF = 360;
  localparam int PAD_W_DEF = IMG_W_DEF + 2;
  localparam int PAD_H_DEF = IMG_H_DEF + 2;
  localparam int COORD_W   = 9;

  // One zero column/row of padding on each side of the active image.
  function automatic int pad_dim(input int n);
    return n + 2;
  endfunction

endpackage

// File: rtl/edge_raster_cnt.sv
// Column/row raster walker over a COLS x ROWS grid; steps one position per enable.
module edge_raster_cnt #(
  parameter int COLS = 6,
  parameter int ROWS = 5,
  localparam int CW = $clog2(COLS),
  localparam int RW = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          wrap,
  output logic          last
);

  // wrap/last describe the current position, so callers can decode edges before stepping.
  assign wrap = (col == CW'(COLS - 1));
  assign last = wrap && (row == RW'(ROWS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (clr) begin
      col <= '0;
      row <= '0;
    end else if (en) begin
      if (wrap) begin
        col <= '0;
        row <= last ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/edge_frame_ctrl.sv
// Frame sequencer: feeds a zero-padded raster into the edge datapath, flushes its
// line-buffer latency, and returns interior results tagged with (x,y).
module edge_frame_ctrl
  import edge_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int LAT   = IMG_W + 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_r,
  input  logic [7:0]         in_g,
  input  logic [7:0]         in_b,
  output logic               dp_en,
  output logic [7:0]         dp_r,
  output logic [7:0]         dp_g,
  output logic [7:0]         dp_b,
  input  logic [7:0]         dp_edge_x,
  input  logic [7:0]         dp_edge_y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y,
  output logic [7:0]         out_edge_x,
  output logic [7:0]         out_edge_y,
  output logic               out_last
);

  localparam int PAD_W = pad_dim(IMG_W);
  localparam int PAD_H = pad_dim(IMG_H);
  localparam int CW    = $clog2(PAD_W);
  localparam int RW    = $clog2(PAD_H);
  localparam int LW    = $clog2(LAT + 1);

  state_t          state_reg, state_next;
  logic [LW-1:0]   lat_cnt_reg;
  logic            primed, stall, cnt_clr, issue_en, out_en;
  logic            issue_pad, out_interior;
  logic [CW-1:0]   icol, ocol;
  logic [RW-1:0]   irow, orow;
  logic            iwrap, ilast, owrap, olast;

  assign stall    = out_valid && !out_ready;
  assign primed   = (lat_cnt_reg == LW'(LAT));
  assign cnt_clr  = abort || (state_reg == IDLE);
  assign issue_en = dp_en && (state_reg == FEED);
  assign out_en   = dp_en && primed;
  assign busy     = (state_reg == FEED) || (state_reg == FLUSH);
  assign done     = (state_reg == DONE);

  assign issue_pad    = (icol == '0) || iwrap || (irow == '0) || (irow == RW'(PAD_H - 1));
  assign out_interior = (ocol != '0) && !owrap && (orow != '0) && (orow != RW'(PAD_H - 1));

  edge_raster_cnt #(.COLS(PAD_W), .ROWS(PAD_H)) u_issue_cnt (
    .clk(clk), .rst(rst), .en(issue_en), .clr(cnt_clr),
    .col(icol), .row(irow), .wrap(iwrap), .last(ilast)
  );

  // Trails the issue side by LAT enables: points at the padded index whose result is on dp_edge_*.
  edge_raster_cnt #(.COLS(PAD_W), .ROWS(PAD_H)) u_out_cnt (
    .clk(clk), .rst(rst), .en(out_en), .clr(cnt_clr),
    .col(ocol), .row(orow), .wrap(owrap), .last(olast)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 lat_cnt_reg <= '0;
    else if (cnt_clr)         lat_cnt_reg <= '0;
    else if (dp_en && !primed) lat_cnt_reg <= lat_cnt_reg + LW'(1);
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    dp_en      = 1'b0;
    dp_r       = '0;
    dp_g       = '0;
    dp_b       = '0;
    case (state_reg)
      IDLE: if (start) state_next = FEED;
      FEED: begin
        if (issue_pad) begin
          dp_en = !stall;
        end else begin
          in_ready = !stall;
          dp_en    = in_valid && !stall;
          dp_r     = in_r;
          dp_g     = in_g;
          dp_b     = in_b;
        end
        if (dp_en && ilast) state_next = FLUSH;
      end
      // The flush ends when the trailing counter reaches the final padded index.
      FLUSH: begin
        dp_en = !stall;
        if (dp_en && olast) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) begin
      state_next = IDLE;
      in_ready   = 1'b0;
      dp_en      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      out_x      <= '0;
      out_y      <= '0;
      out_edge_x <= '0;
      out_edge_y <= '0;
      out_last   <= 1'b0;
    end else if (abort) begin
      out_valid  <= 1'b0;
      out_x      <= '0;
      out_y      <= '0;
      out_edge_x <= '0;
      out_edge_y <= '0;
      out_last   <= 1'b0;
    end else if (out_en && out_interior) begin
      out_valid  <= 1'b1;
      out_x      <= COORD_W'(ocol - CW'(1));
      out_y      <= COORD_W'(orow - RW'(1));
      out_edge_x <= dp_edge_x;
      out_edge_y <= dp_edge_y;
      out_last   <= (ocol == CW'(IMG_W)) && (orow == RW'(IMG_H));
    end else if (out_valid && out_ready) begin
      out_valid  <= 1'b0;
      out_x      <= '0;
      out_y      <= '0;
      out_edge_x <= '0;
      out_edge_y <= '0;
      out_last   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_edge_frame_ctrl.sv
// Randomized bench for edge_frame_ctrl at 4x3: a raster-order result model plus a
// stand-in datapath that returns the pixel issued LAT enables earlier.
module tb_edge_frame_ctrl;

  localparam int IMG_W = 4;
  localparam int IMG_H = 3;
  localparam int LAT   = 6;
  localparam int PAD_W = IMG_W + 2;
  localparam int PAD_H = IMG_H + 2;
  localparam int TOTAL = PAD_W * PAD_H;
  localparam int NPIX  = IMG_W * IMG_H;

  logic       clk = 1'b0;
  logic       rst, start, abort, in_valid, out_ready;
  logic [7:0] in_r, in_g, in_b, dp_edge_x, dp_edge_y;
  logic       busy, done, in_ready, dp_en, out_valid, out_last;
  logic [7:0] dp_r, dp_g, dp_b, out_edge_x, out_edge_y;
  logic [8:0] out_x, out_y;

  edge_frame_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .dp_en(dp_en), .dp_r(dp_r), .dp_g(dp_g), .dp_b(dp_b),
    .dp_edge_x(dp_edge_x), .dp_edge_y(dp_edge_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .out_edge_x(out_edge_x), .out_edge_y(out_edge_y), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0, start_cyc = 0;
  int valid_pct = 100, ready_pct = 100;
  bit force_lo = 1'b0;
  logic [7:0] px_r [NPIX];
  logic [7:0] px_g [NPIX];
  logic [7:0] px_b [NPIX];
  logic [7:0] hist_r  [TOTAL+LAT];
  logic [7:0] hist_gb [TOTAL+LAT];
  int src_idx = 0, dp_k = 0;
  int n_en = 0, n_noin = 0, n_in = 0, n_out = 0, n_last = 0, done_seen = 0, done_cycle = 0;
  int first_x = -1, first_y = -1, last_x = -1, last_y = -1;
  bit m_active = 0, m_valid = 0, m_done_next = 0, prev_hold = 0;
  int m_k = 0, m_in = 0, m_res = 0;
  logic [34:0] prev_word;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Source and stand-in datapath, updated just after each rising edge.
  initial begin
    in_valid = 0; out_ready = 0; in_r = 0; in_g = 0; in_b = 0;
    dp_edge_x = 0; dp_edge_y = 0;
    forever begin
      @(posedge clk); #1;
      in_valid = ($urandom_range(0, 99) < valid_pct);
      if (src_idx < NPIX) begin
        in_r = px_r[src_idx]; in_g = px_g[src_idx]; in_b = px_b[src_idx];
      end else begin
        in_r = 0; in_g = 0; in_b = 0;
      end
      out_ready = force_lo ? 1'b0 : ($urandom_range(0, 99) < ready_pct);
      if (dp_k >= LAT && dp_k - LAT < TOTAL + LAT) begin
        dp_edge_x = hist_r[dp_k-LAT]; dp_edge_y = hist_gb[dp_k-LAT];
      end else begin
        dp_edge_x = 0; dp_edge_y = 0;
      end
    end
  end

  // Compare process: model of the padded walk and raster-order results.
  always @(negedge clk) begin
    logic e_dp_en, e_in_ready, pad, stall, cur_done, was_idle;
    logic [7:0] er, eg, eb;
    int pc, pr, q, qc, qr;
    cyc++;
    if (!rst) begin
      m_active = 0; m_valid = 0; m_done_next = 0; prev_hold = 0;
    end else begin
      cur_done = m_done_next;
      was_idle = !m_active && !cur_done;
      stall = m_valid && !out_ready;
      e_dp_en = 0; e_in_ready = 0; pad = 1;
      if (m_active) begin
        if (m_k < TOTAL) begin
          pc = m_k % PAD_W; pr = m_k / PAD_W;
          pad = (pc == 0) || (pc == PAD_W-1) || (pr == 0) || (pr == PAD_H-1);
          if (pad) e_dp_en = !stall;
          else begin e_in_ready = !stall; e_dp_en = in_valid && !stall; end
        end else begin
          e_dp_en = !stall;
        end
      end
      chk("busy", busy, m_active);
      chk("done", done, cur_done);
      chk("out_valid", out_valid, m_valid);
      if (!abort) begin
        chk("dp_en", dp_en, e_dp_en);
        chk("in_ready", in_ready, e_in_ready);
      end
      if (m_active && e_dp_en && !abort) begin
        er = 0; eg = 0; eb = 0;
        if (!pad && m_in < NPIX) begin er = px_r[m_in]; eg = px_g[m_in]; eb = px_b[m_in]; end
        chk("dp_rgb", {dp_r, dp_g, dp_b}, {er, eg, eb});
      end
      if (m_valid && out_valid && m_res < NPIX) begin
        chk("out_x", out_x, m_res % IMG_W);
        chk("out_y", out_y, m_res / IMG_W);
        chk("out_edge_x", out_edge_x, px_r[m_res]);
        chk("out_edge_y", out_edge_y, px_g[m_res] ^ px_b[m_res]);
        chk("out_last", out_last, m_res == NPIX-1);
      end
      if (prev_hold) chk("out_hold", {out_x, out_y, out_edge_x, out_edge_y, out_last}, prev_word);
      prev_hold = out_valid && !out_ready && !abort;
      prev_word = {out_x, out_y, out_edge_x, out_edge_y, out_last};

      if (dp_en) begin
        n_en++;
        if (!in_ready) n_noin++;
        if (dp_k < TOTAL + LAT) begin hist_r[dp_k] = dp_r; hist_gb[dp_k] = dp_g ^ dp_b; end
        dp_k++;
      end
      if (in_valid && in_ready) begin n_in++; src_idx++; end
      if (out_valid && out_ready) begin
        $display("result x=%0d y=%0d edge_x=%0d edge_y=%0d last=%0d", out_x, out_y, out_edge_x, out_edge_y, out_last);
        if (n_out == 0) begin first_x = int'(out_x); first_y = int'(out_y); end
        if (out_last) begin n_last++; last_x = int'(out_x); last_y = int'(out_y); end
        n_out++;
      end
      if (done) begin done_seen++; done_cycle = cyc - start_cyc; end

      m_done_next = 0;
      if (abort) begin
        m_active = 0; m_valid = 0;
      end else begin
        if (m_valid && out_ready) begin m_valid = 0; m_res++; end
        if (e_dp_en) begin
          if (m_k >= LAT) begin
            q = m_k - LAT; qc = q % PAD_W; qr = q / PAD_W;
            if (qc >= 1 && qc <= IMG_W && qr >= 1 && qr <= IMG_H) m_valid = 1;
          end
          if (m_k < TOTAL && !pad) m_in++;
          m_k++;
          if (m_k == TOTAL + LAT) begin m_active = 0; m_done_next = 1; end
        end
        if (start && was_idle) begin
          m_active = 1; m_k = 0; m_in = 0; m_res = 0; m_valid = 0;
          src_idx = 0; dp_k = 0; start_cyc = cyc;
          n_en = 0; n_noin = 0; n_in = 0; n_out = 0; n_last = 0; done_seen = 0;
          first_x = -1; first_y = -1; last_x = -1; last_y = -1;
        end
      end
    end
  end

  task automatic new_pixels();
    for (int i = 0; i < NPIX; i++) begin
      px_r[i] = 8'($urandom_range(0, 255));
      px_g[i] = 8'($urandom_range(0, 255));
      px_b[i] = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_seen == 0 && n < budget) begin @(posedge clk); n++; end
    chk("frame_done_seen", done_seen, 1);
    repeat (2) @(posedge clk);
  endtask

  task automatic frame_counts(input string tag);
    chk({tag, "_dp_en_cycles"}, n_en, 36);
    chk({tag, "_in_beats"}, n_in, 12);
    chk({tag, "_out_beats"}, n_out, 12);
    chk({tag, "_last_count"}, n_last, 1);
    chk({tag, "_last_xy"}, {last_x[15:0], last_y[15:0]}, {16'd3, 16'd2});
    chk({tag, "_first_xy"}, {first_x[15:0], first_y[15:0]}, {16'd0, 16'd0});
  endtask

  initial begin
    int n;
    rst = 0; start = 0; abort = 0;
    new_pixels();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_dp_en", dp_en, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_xy", {out_x, out_y, out_last}, 0);
    @(posedge clk); #1 rst = 1;

    // Clean frame: fixed latency and enable counts.
    valid_pct = 100; ready_pct = 100;
    pulse_start(); wait_done(500);
    frame_counts("clean");
    chk("clean_done_latency", done_cycle, 37);
    chk("clean_zero_rgb_enables", n_noin, 24);

    // Sparse input valid, plus a start pulse mid-frame that must be ignored.
    new_pixels(); valid_pct = 70;
    pulse_start();
    n = 0;
    while (n_en < 10 && n < 300) begin @(posedge clk); n++; end
    pulse_start(); wait_done(1000);
    frame_counts("sparse");
    chk("sparse_zero_rgb_enables", n_noin, 24);

    // Sink holds off for ten cycles mid-frame.
    new_pixels(); valid_pct = 100;
    pulse_start();
    n = 0;
    while (n_en < 14 && n < 300) begin @(posedge clk); #2; n++; end
    force_lo = 1;
    repeat (10) @(posedge clk);
    #2 force_lo = 0;
    wait_done(1000);
    frame_counts("stall");

    // Random backpressure on both sides.
    new_pixels(); valid_pct = 70; ready_pct = 60;
    pulse_start(); wait_done(2000);
    frame_counts("random");

    // Abort on the fifth input beat, then abort+start together while idle.
    new_pixels(); valid_pct = 100; ready_pct = 100;
    pulse_start();
    n = 0;
    while (src_idx < 4 && n < 300) begin @(posedge clk); #2; n++; end
    abort = 1;
    @(posedge clk); #2 abort = 0;
    repeat (5) @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_no_done", done_seen, 0);
    @(posedge clk); #2 start = 1; abort = 1;
    @(posedge clk); #2 start = 0; abort = 0;
    @(negedge clk);
    chk("abort_beats_start_busy", busy, 0);
    pulse_start(); wait_done(500);
    frame_counts("after_abort");
    chk("after_abort_done_latency", done_cycle, 37);

    // Asynchronous reset in the middle of FEED.
    new_pixels();
    pulse_start();
    repeat (8) @(posedge clk);
    @(negedge clk); #2 rst = 0;
    #1;
    chk("midreset_busy", busy, 0);
    chk("midreset_in_ready", in_ready, 0);
    chk("midreset_dp_en", dp_en, 0);
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_done", done, 0);
    @(posedge clk); @(posedge clk); #1 rst = 1;
    new_pixels();
    pulse_start(); wait_done(500);
    frame_counts("after_reset");
    chk("after_reset_done_latency", done_cycle, 37);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
